keypad_scanner: RTL

// Scans the 4x3 matrix keypad, debounces it and sends clean single-cycle press events
// (key_pulse/key_code) to downstream consumers such as level_select and in-game input.

---
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, 2-FF row sync, frame debounce,
// and a single-press event FSM that rejects multi-key chords.
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_row,
   output logic [2:0]  key_col,
   output logic [11:0] key_pulse,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_LOCKED
   } state_t;

   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_sync;
   logic [DW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [2:0]    r_col_oh;
   logic [11:0]   r_raw;
   logic [11:0]   r_prev;
   logic [11:0]   r_deb;
   logic [SW-1:0] r_stable;
   state_t        r_state;
   logic [11:0]   r_pulse;
   logic [3:0]    r_code;
   logic          r_valid;
   logic          r_held;

   logic          w_last;
   logic          w_frame_done;
   logic [11:0]   w_frame;
   logic [SW-1:0] w_stable_nxt;
   logic          w_commit;
   logic [3:0]    w_nkeys;
   logic [3:0]    w_code;

   // Frame bits are indexed by key code, so a one-hot frame is the event itself.
   function automatic logic [3:0] f_key(input logic [1:0] row,
                                        input logic [1:0] col);
      logic [3:0] v;
      v = 4'd0;
      unique case (row)
         2'd0:    v = 4'd1 + {2'b00, col};
         2'd1:    v = 4'd4 + {2'b00, col};
         2'd2:    v = 4'd7 + {2'b00, col};
         default: v = (col == 2'd0) ? 4'd10 :
                      (col == 2'd1) ? 4'd0 : 4'd11;
      endcase
      return v;
   endfunction

   assign w_last       = (r_dwell == DWELL_LAST);
   assign w_frame_done = w_last && (r_col == 2'd2);

   always_comb begin
      w_frame = r_raw;
      for (int r = 0; r < 4; r++) begin
         w_frame[f_key(2'(r), r_col)] = r_row_sync[r];
      end
   end

   always_comb begin
      w_stable_nxt = SW'(1);
      if (w_frame == r_prev) begin
         w_stable_nxt = (r_stable == STABLE_MAX) ?
                        r_stable : r_stable + SW'(1);
      end
   end

   assign w_commit = w_frame_done &&
                     (w_stable_nxt == STABLE_MAX) &&
                     (w_frame != r_deb);

   always_comb begin
      w_nkeys = 4'd0;
      w_code  = 4'hF;
      for (int i = 0; i < 12; i++) begin
         if (w_frame[i]) begin
            w_nkeys = w_nkeys + 4'd1;
            w_code  = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_meta <= '0;
         r_row_sync <= '0;
         r_dwell    <= '0;
         r_col      <= 2'd0;
         r_col_oh   <= 3'b001;
         r_raw      <= '0;
         r_prev     <= '0;
         r_deb      <= '0;
         r_stable   <= '0;
         r_state    <= ST_IDLE;
         r_pulse    <= '0;
         r_code     <= 4'hF;
         r_valid    <= 1'b0;
         r_held     <= 1'b0;
      end else begin
         r_row_meta <= key_row;
         r_row_sync <= r_row_meta;
         r_pulse    <= '0;
         r_valid    <= 1'b0;

         if (w_last) begin
            r_dwell  <= '0;
            r_raw    <= w_frame;
            r_col    <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
            r_col_oh <= {r_col_oh[1:0], r_col_oh[2]};
         end else begin
            r_dwell <= r_dwell + DW'(1);
         end

         if (w_frame_done) begin
            r_prev   <= w_frame;
            r_stable <= w_stable_nxt;
         end

         // A fresh key is accepted only from IDLE, i.e. after a full release.
         if (w_commit) begin
            r_deb <= w_frame;
            unique case (r_state)
               ST_IDLE: begin
                  if (w_nkeys == 4'd1) begin
                     r_state <= ST_PRESSED;
                     r_pulse <= w_frame;
                     r_valid <= 1'b1;
                     r_code  <= w_code;
                     r_held  <= 1'b1;
                  end else if (w_nkeys >= 4'd2) begin
                     r_state <= ST_LOCKED;
                  end
               end
               ST_PRESSED: begin
                  r_held  <= 1'b0;
                  r_state <= (w_nkeys == 4'd0) ? ST_IDLE : ST_LOCKED;
               end
               ST_LOCKED: begin
                  if (w_nkeys == 4'd0) r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign key_col   = r_col_oh;
   assign key_pulse = r_pulse;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;

endmodule
